// File: rtl/regfile_pkg.sv
// Shared register-file constants and writeback types used by the arbiter
// and its hazard scoreboard.
package regfile_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int STARVE_W   = 3;

    // Which requester, if any, owns the write port this cycle.
    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_A    = 2'd1,
        GRANT_M    = 2'd2
    } grant_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    // Writes to x0 are architecturally discarded.
    function automatic logic is_x0(input logic [REG_ADDR_W-1:0] addr);
        return addr == '0;
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-destination scoreboard: one bit per architectural register,
// set by issue, cleared when the matching writeback is accepted.
module wb_scoreboard
    import regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    input  logic [REG_ADDR_W-1:0] chk_rs1,
    input  logic [REG_ADDR_W-1:0] chk_rs2,
    output logic                  stall
);

    // x0 can never be pending, so its bit is masked off every update.
    localparam logic [NUM_REGS-1:0] X0_MASK = ~{{(NUM_REGS-1){1'b0}}, 1'b1};

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;

    // One-hot decode of the set and clear addresses.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_decode
        assign set_vec[gi] = set_en && (set_addr == REG_ADDR_W'(gi));
        assign clr_vec[gi] = clr_en && (clr_addr == REG_ADDR_W'(gi));
    end

    // Next pending state: clear first, then set, so a same-edge set wins.
    always_comb begin
        pending_d = ((pending_q & ~clr_vec) | set_vec) & X0_MASK;
    end

    // Pending bit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Hazard check uses only registered state; a same-cycle set is not seen.
    assign stall = pending_q[chk_rs1] | pending_q[chk_rs2];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-source register-file writeback arbiter. The ALU port (A) wins by
// default; the load/multi-cycle port (M) is forced through once it has
// been stalled STARVE_LIMIT consecutive cycles. The accepted write reaches
// the register file one cycle later, and a scoreboard tracks pending
// destinations for the issue-stage hazard check.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [REG_ADDR_W-1:0] a_addr,
    input  logic [XLEN-1:0]       a_data,
    input  logic                  m_valid,
    output logic                  m_ready,
    input  logic [REG_ADDR_W-1:0] m_addr,
    input  logic [XLEN-1:0]       m_data,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_wraddr,
    output logic [XLEN-1:0]       rf_wrdata,
    input  logic                  pend_set,
    input  logic [REG_ADDR_W-1:0] pend_addr,
    input  logic [REG_ADDR_W-1:0] chk_rs1,
    input  logic [REG_ADDR_W-1:0] chk_rs2,
    output logic                  stall
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0]   starve_cnt_q;
    logic [STARVE_W-1:0]   starve_cnt_d;
    logic                  m_force;
    grant_e                grant;
    wb_req_t               win_req;
    logic                  accept;

    logic                  rf_we_q;
    logic                  rf_we_d;
    logic [REG_ADDR_W-1:0] rf_wraddr_q;
    logic [REG_ADDR_W-1:0] rf_wraddr_d;
    logic [XLEN-1:0]       rf_wrdata_q;
    logic [XLEN-1:0]       rf_wrdata_d;

    assign m_force = (starve_cnt_q == LIMIT);

    // Grant selection: A by default, M when A is idle or M is starving.
    // Nothing is granted while reset is held.
    always_comb begin
        grant = GRANT_NONE;
        if (rst_n) begin
            if (m_valid && (!a_valid || m_force)) begin
                grant = GRANT_M;
            end else if (a_valid && !m_force) begin
                grant = GRANT_A;
            end
        end
    end

    assign a_ready = (grant == GRANT_A);
    assign m_ready = (grant == GRANT_M);
    assign accept  = (grant != GRANT_NONE);

    // Winning request payload.
    always_comb begin
        win_req = '{addr: a_addr, data: a_data};
        if (grant == GRANT_M) begin
            win_req = '{addr: m_addr, data: m_data};
        end
    end

    // Starvation counter: counts consecutive stalled M cycles, saturating.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!m_valid || m_ready) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != LIMIT) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    // Register-file write port next state; x0 writes are accepted but dropped.
    always_comb begin
        rf_we_d     = accept && !is_x0(win_req.addr);
        rf_wraddr_d = rf_wraddr_q;
        rf_wrdata_d = rf_wrdata_q;
        if (accept) begin
            rf_wraddr_d = win_req.addr;
            rf_wrdata_d = win_req.data;
        end
    end

    // Arbiter and write-port state; reset also kills any in-flight write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
            rf_we_q      <= 1'b0;
            rf_wraddr_q  <= '0;
            rf_wrdata_q  <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rf_we_q      <= rf_we_d;
            rf_wraddr_q  <= rf_wraddr_d;
            rf_wrdata_q  <= rf_wrdata_d;
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_wraddr = rf_wraddr_q;
    assign rf_wrdata = rf_wrdata_q;

    wb_scoreboard u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (pend_set),
        .set_addr (pend_addr),
        .clr_en   (accept),
        .clr_addr (win_req.addr),
        .chk_rs1  (chk_rs1),
        .chk_rs2  (chk_rs2),
        .stall    (stall)
    );

endmodule
